control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit for a simple bus-based CPU datapath. It walks the
//   fetch cycle (T0..T2), then one instruction-specific execute sequence
//   (EXEC3..EXEC7), and returns to T0. A halt instruction or a Stop request
//   in T0 parks the block in HALT until clear.
//
// Ports
//   clock      in   system clock, all state changes on the rising edge
//   clear      in   synchronous active-high reset
//   IR[31:0]   in   instruction register; IR[31:27] is the opcode
//   Stop       in   halt request, honoured only while in T0
//   PCout .. ADD    out  datapath strobes, active high
//   Run        out  high while sequencing (T0..EXEC7)
//   Illegal    out  high for the EXEC3 cycle of an undefined opcode
//   State[4:0] out  current state encoding, debug only
//
// Every output is registered and computed from the state being entered, so
// each strobe is stable for the whole state cycle and never glitches.
// -----------------------------------------------------------------------------
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MAR_clear,
  output logic        Read,
  output logic        MD_read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Csignout,
  output logic        ADD,
  output logic        Run,
  output logic        Illegal,
  output logic [4:0]  State
);

  typedef enum logic [4:0] {
    ST_RESET = 5'd0,
    ST_T0    = 5'd1,
    ST_T1    = 5'd2,
    ST_T2    = 5'd3,
    ST_EXEC3 = 5'd4,
    ST_EXEC4 = 5'd5,
    ST_EXEC5 = 5'd6,
    ST_EXEC6 = 5'd7,
    ST_EXEC7 = 5'd8,
    ST_HALT  = 5'd9
  } state_t;

  // Instruction class remembered for the whole execute sequence, so the
  // datapath is free to change IR once it has been sampled.
  typedef enum logic [2:0] {
    OP_LDI,
    OP_LD,
    OP_ADD,
    OP_JR,
    OP_NOP,
    OP_ILL
  } op_t;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_JR   = 5'b10100;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  // Bit positions inside the packed output vector.
  localparam int B_PCOUT     = 0;
  localparam int B_PCIN      = 1;
  localparam int B_INCPC     = 2;
  localparam int B_MARIN     = 3;
  localparam int B_MAR_CLEAR = 4;
  localparam int B_READ      = 5;
  localparam int B_MD_READ   = 6;
  localparam int B_MDRIN     = 7;
  localparam int B_MDROUT    = 8;
  localparam int B_IRIN      = 9;
  localparam int B_YIN       = 10;
  localparam int B_ZLOWIN    = 11;
  localparam int B_ZLOWOUT   = 12;
  localparam int B_GRA       = 13;
  localparam int B_GRB       = 14;
  localparam int B_GRC       = 15;
  localparam int B_RIN       = 16;
  localparam int B_ROUT      = 17;
  localparam int B_BAOUT     = 18;
  localparam int B_CSIGNOUT  = 19;
  localparam int B_ADD       = 20;
  localparam int B_RUN       = 21;
  localparam int B_ILLEGAL   = 22;
  localparam int N_OUT       = 23;

  state_t             r_state;
  op_t                r_op;
  logic [N_OUT-1:0]   r_out;

  state_t             w_state_next;
  op_t                w_op_next;
  logic [4:0]         w_opcode;
  logic               w_ir_unused;

  assign w_opcode    = IR[31:27];
  assign w_ir_unused = ^IR[26:0];

  function automatic op_t classify(input logic [4:0] opc);
    op_t c;
    case (opc)
      OPC_LD:  c = OP_LD;
      OPC_LDI: c = OP_LDI;
      OPC_ADD: c = OP_ADD;
      OPC_JR:  c = OP_JR;
      OPC_NOP: c = OP_NOP;
      default: c = OP_ILL;
    endcase
    return c;
  endfunction

  // Output pattern for a given state / instruction class.
  function automatic logic [N_OUT-1:0] decode_outputs(input state_t s, input op_t op);
    logic [N_OUT-1:0] v;
    v = '0;
    case (s)
      ST_RESET: v[B_MAR_CLEAR] = 1'b1;
      ST_T0: begin
        v[B_RUN]    = 1'b1;
        v[B_PCOUT]  = 1'b1;
        v[B_MARIN]  = 1'b1;
        v[B_INCPC]  = 1'b1;
        v[B_ZLOWIN] = 1'b1;
      end
      ST_T1: begin
        v[B_RUN]     = 1'b1;
        v[B_ZLOWOUT] = 1'b1;
        v[B_PCIN]    = 1'b1;
        v[B_READ]    = 1'b1;
        v[B_MD_READ] = 1'b1;
        v[B_MDRIN]   = 1'b1;
      end
      ST_T2: begin
        v[B_RUN]    = 1'b1;
        v[B_MDROUT] = 1'b1;
        v[B_IRIN]   = 1'b1;
      end
      ST_EXEC3: begin
        v[B_RUN] = 1'b1;
        case (op)
          OP_LDI, OP_LD: begin
            v[B_GRB]   = 1'b1;
            v[B_BAOUT] = 1'b1;
            v[B_YIN]   = 1'b1;
          end
          OP_ADD: begin
            v[B_GRB]  = 1'b1;
            v[B_ROUT] = 1'b1;
            v[B_YIN]  = 1'b1;
          end
          OP_JR: begin
            v[B_GRA]  = 1'b1;
            v[B_ROUT] = 1'b1;
            v[B_PCIN] = 1'b1;
          end
          OP_ILL:  v[B_ILLEGAL] = 1'b1;
          default: ;  // nop: idle cycle
        endcase
      end
      ST_EXEC4: begin
        v[B_RUN] = 1'b1;
        if (op == OP_ADD) begin
          v[B_GRC]    = 1'b1;
          v[B_ROUT]   = 1'b1;
          v[B_ADD]    = 1'b1;
          v[B_ZLOWIN] = 1'b1;
        end else begin
          v[B_CSIGNOUT] = 1'b1;
          v[B_ADD]      = 1'b1;
          v[B_ZLOWIN]   = 1'b1;
        end
      end
      ST_EXEC5: begin
        v[B_RUN]     = 1'b1;
        v[B_ZLOWOUT] = 1'b1;
        if (op == OP_LD) begin
          v[B_MARIN] = 1'b1;   // effective address goes to MAR
        end else begin
          v[B_GRA] = 1'b1;
          v[B_RIN] = 1'b1;
        end
      end
      ST_EXEC6: begin
        v[B_RUN]     = 1'b1;
        v[B_READ]    = 1'b1;
        v[B_MD_READ] = 1'b1;
        v[B_MDRIN]   = 1'b1;
      end
      ST_EXEC7: begin
        v[B_RUN]    = 1'b1;
        v[B_MDROUT] = 1'b1;
        v[B_GRA]    = 1'b1;
        v[B_RIN]    = 1'b1;
      end
      default: ;  // HALT: everything low
    endcase
    return v;
  endfunction

  // Next-state logic. The opcode is sampled on the edge that leaves T2,
  // i.e. the instruction must be present on IR by the end of T2.
  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    case (r_state)
      ST_RESET: w_state_next = ST_T0;
      ST_T0:    w_state_next = Stop ? ST_HALT : ST_T1;
      ST_T1:    w_state_next = ST_T2;
      ST_T2: begin
        if (w_opcode == OPC_HALT) begin
          w_state_next = ST_HALT;
        end else begin
          w_state_next = ST_EXEC3;
          w_op_next    = classify(w_opcode);
        end
      end
      ST_EXEC3: begin
        if (r_op == OP_LDI || r_op == OP_LD || r_op == OP_ADD)
          w_state_next = ST_EXEC4;
        else
          w_state_next = ST_T0;
      end
      ST_EXEC4: w_state_next = ST_EXEC5;
      ST_EXEC5: w_state_next = (r_op == OP_LD) ? ST_EXEC6 : ST_T0;
      ST_EXEC6: w_state_next = ST_EXEC7;
      ST_EXEC7: w_state_next = ST_T0;
      ST_HALT:  w_state_next = ST_HALT;
      default:  w_state_next = ST_RESET;
    endcase
  end

  // Single state register; outputs are registered alongside it from the
  // state being entered so they line up exactly with the state cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= ST_RESET;
      r_op    <= OP_NOP;
      r_out   <= decode_outputs(ST_RESET, OP_NOP);
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_out   <= decode_outputs(w_state_next, w_op_next);
    end
  end

  assign PCout     = r_out[B_PCOUT];
  assign PCin      = r_out[B_PCIN];
  assign IncPC     = r_out[B_INCPC];
  assign MARin     = r_out[B_MARIN];
  assign MAR_clear = r_out[B_MAR_CLEAR];
  assign Read      = r_out[B_READ];
  assign MD_read   = r_out[B_MD_READ];
  assign MDRin     = r_out[B_MDRIN];
  assign MDRout    = r_out[B_MDROUT];
  assign IRin      = r_out[B_IRIN];
  assign Yin       = r_out[B_YIN];
  assign Zlowin    = r_out[B_ZLOWIN];
  assign Zlowout   = r_out[B_ZLOWOUT];
  assign Gra       = r_out[B_GRA];
  assign Grb       = r_out[B_GRB];
  assign Grc       = r_out[B_GRC];
  assign Rin       = r_out[B_RIN];
  assign Rout      = r_out[B_ROUT];
  assign BAout     = r_out[B_BAOUT];
  assign Csignout  = r_out[B_CSIGNOUT];
  assign ADD       = r_out[B_ADD];
  assign Run       = r_out[B_RUN];
  assign Illegal   = r_out[B_ILLEGAL];
  assign State     = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//   Randomized scoreboard bench. The stimulus process expands each issued
//   instruction into its expected per-cycle strobe pattern (taken from the
//   instruction timing tables) and queues one entry per clock cycle; a monitor
//   samples the outputs on the falling edge and compares against the queue.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR    = '0;
  logic        Stop  = 1'b0;
  logic PCout, PCin, IncPC, MARin, MAR_clear, Read, MD_read, MDRin, MDRout, IRin;
  logic Yin, Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Csignout, ADD;
  logic Run, Illegal;
  logic [4:0] State;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .Stop(Stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MAR_clear(MAR_clear),
    .Read(Read), .MD_read(MD_read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Csignout(Csignout), .ADD(ADD),
    .Run(Run), .Illegal(Illegal), .State(State)
  );

  always #5 clock = ~clock;

  // Bench-side strobe masks.
  localparam logic [20:0] M_PCOUT    = 21'd1 << 0;
  localparam logic [20:0] M_PCIN     = 21'd1 << 1;
  localparam logic [20:0] M_INCPC    = 21'd1 << 2;
  localparam logic [20:0] M_MARIN    = 21'd1 << 3;
  localparam logic [20:0] M_MARCLR   = 21'd1 << 4;
  localparam logic [20:0] M_READ     = 21'd1 << 5;
  localparam logic [20:0] M_MDREAD   = 21'd1 << 6;
  localparam logic [20:0] M_MDRIN    = 21'd1 << 7;
  localparam logic [20:0] M_MDROUT   = 21'd1 << 8;
  localparam logic [20:0] M_IRIN     = 21'd1 << 9;
  localparam logic [20:0] M_YIN      = 21'd1 << 10;
  localparam logic [20:0] M_ZLOWIN   = 21'd1 << 11;
  localparam logic [20:0] M_ZLOWOUT  = 21'd1 << 12;
  localparam logic [20:0] M_GRA      = 21'd1 << 13;
  localparam logic [20:0] M_GRB      = 21'd1 << 14;
  localparam logic [20:0] M_GRC      = 21'd1 << 15;
  localparam logic [20:0] M_RIN      = 21'd1 << 16;
  localparam logic [20:0] M_ROUT     = 21'd1 << 17;
  localparam logic [20:0] M_BAOUT    = 21'd1 << 18;
  localparam logic [20:0] M_CSIGN    = 21'd1 << 19;
  localparam logic [20:0] M_ADD      = 21'd1 << 20;

  logic [20:0] dut_s;
  assign dut_s = {ADD, Csignout, BAout, Rout, Rin, Grc, Grb, Gra, Zlowout, Zlowin,
                  Yin, IRin, MDRout, MDRin, MD_read, Read, MAR_clear, MARin, IncPC,
                  PCin, PCout};

  typedef struct {
    int          cyc;
    logic [20:0] s;
    logic        run;
    logic        ill;
    logic        is_reset;  // 1: State must read 0; 0: State must be nonzero
  } exp_t;

  exp_t sb[$];
  exp_t plan[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [20:0] s, input logic run, input logic ill,
                              input logic rst);
    exp_t e;
    e.cyc = 0; e.s = s; e.run = run; e.ill = ill; e.is_reset = rst;
    return e;
  endfunction

  function automatic exp_t e_reset();
    return mk(M_MARCLR, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic exp_t e_halt();
    return mk(21'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Reference model: the full cycle list of one instruction, from T0 onward.
  task automatic build_plan(input logic [4:0] op);
    plan.delete();
    plan.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 1, 0, 0));
    plan.push_back(mk(M_ZLOWOUT | M_PCIN | M_READ | M_MDREAD | M_MDRIN, 1, 0, 0));
    plan.push_back(mk(M_MDROUT | M_IRIN, 1, 0, 0));
    case (op)
      5'b00001: begin  // ldi
        plan.push_back(mk(M_GRB | M_BAOUT | M_YIN, 1, 0, 0));
        plan.push_back(mk(M_CSIGN | M_ADD | M_ZLOWIN, 1, 0, 0));
        plan.push_back(mk(M_ZLOWOUT | M_GRA | M_RIN, 1, 0, 0));
      end
      5'b00000: begin  // ld
        plan.push_back(mk(M_GRB | M_BAOUT | M_YIN, 1, 0, 0));
        plan.push_back(mk(M_CSIGN | M_ADD | M_ZLOWIN, 1, 0, 0));
        plan.push_back(mk(M_ZLOWOUT | M_MARIN, 1, 0, 0));
        plan.push_back(mk(M_READ | M_MDREAD | M_MDRIN, 1, 0, 0));
        plan.push_back(mk(M_MDROUT | M_GRA | M_RIN, 1, 0, 0));
      end
      5'b00011: begin  // add
        plan.push_back(mk(M_GRB | M_ROUT | M_YIN, 1, 0, 0));
        plan.push_back(mk(M_GRC | M_ROUT | M_ADD | M_ZLOWIN, 1, 0, 0));
        plan.push_back(mk(M_ZLOWOUT | M_GRA | M_RIN, 1, 0, 0));
      end
      5'b10100: plan.push_back(mk(M_GRA | M_ROUT | M_PCIN, 1, 0, 0));  // jr
      5'b11010: plan.push_back(mk(21'd0, 1, 0, 0));                    // nop
      5'b11011: plan.push_back(e_halt());                              // halt
      default:  plan.push_back(mk(21'd0, 1, 1, 0));                    // undefined
    endcase
  endtask

  // Drive inputs for the next rising edge and queue the expected outputs
  // for the cycle that edge starts.
  task automatic step(input logic clr, input logic [31:0] ir, input logic stp,
                      input exp_t e);
    clear = clr; IR = ir; Stop = stp;
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear(input int n);
    for (int i = 0; i < n; i++) step(1'b1, $urandom, 1'($urandom_range(0, 1)), e_reset());
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'($urandom_range(0, 1)), e_halt());
  endtask

  // Issue one instruction. The real IR only appears on the edge leaving T2;
  // abort_at (plan index) replaces that cycle's edge with a clear.
  task automatic run_instr(input logic [31:0] ir, input logic stp, input int abort_at,
                           output logic halted);
    build_plan(ir[31:27]);
    halted = 1'b0;
    $display("issue ir=%h op=%b stop=%0d abort_at=%0d cycles=%0d", ir, ir[31:27], stp,
             abort_at, plan.size());
    for (int k = 0; k < plan.size(); k++) begin
      logic [31:0] ir_drv;
      logic        stop_drv;
      ir_drv   = (k == 3) ? ir : $urandom;
      stop_drv = (k == 1) ? stp : 1'($urandom_range(0, 1));
      if (k == 1 && stp) begin
        step(1'b0, ir_drv, 1'b1, e_halt());
        halted = 1'b1;
        return;
      end
      if (k == abort_at) begin
        step(1'b1, ir_drv, stop_drv, e_reset());
        return;
      end
      step(1'b0, ir_drv, stop_drv, plan[k]);
      if (k == 3 && ir[31:27] == 5'b11011) halted = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_ir(input int kind);
    logic [4:0] op;
    case (kind)
      0: op = 5'b00001;
      1: op = 5'b00000;
      2: op = 5'b00011;
      3: op = 5'b10100;
      4: op = 5'b11010;
      5: op = 5'b11011;
      default: begin
        op = 5'($urandom_range(0, 31));
        while (op == 5'b00000 || op == 5'b00001 || op == 5'b00011 ||
               op == 5'b10100 || op == 5'b11010 || op == 5'b11011)
          op = 5'($urandom_range(0, 31));
      end
    endcase
    return {op, 27'($urandom)};
  endfunction

  // Monitor: compare each cycle against the queued expectation.
  always @(negedge clock) begin
    if (cyc >= 1) begin
      int drivers;
      drivers = int'(PCout) + int'(Zlowout) + int'(MDRout) + int'(Rout) + int'(BAout) +
                int'(Csignout);
      checks++;
      if (drivers > 1) begin
        failures++;
        $display("FAIL bus_driver cyc=%0d drivers_high=%0d required<=1", cyc, drivers);
      end
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic ok;
      e = sb.pop_front();
      ok = (e.cyc == cyc) && (dut_s === e.s) && (Run === e.run) && (Illegal === e.ill) &&
           (e.is_reset ? (State === 5'd0) : (State !== 5'd0 && !$isunknown(State)));
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL cycle cyc=%0d/%0d got strobes=%b run=%b ill=%b state=%0d exp strobes=%b run=%b ill=%b state_zero=%b",
                 cyc, e.cyc, dut_s, Run, Illegal, State, e.s, e.run, e.ill, e.is_reset);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d stimulus did not complete", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    do_clear(2);
    run_instr(32'h0880_0005, 1'b0, -1, h);               // ldi R1,5(R0)
    run_instr({5'b00000, 27'($urandom)}, 1'b0, -1, h);   // ld
    run_instr({5'b00011, 27'($urandom)}, 1'b0, -1, h);   // add
    run_instr({5'b10100, 27'($urandom)}, 1'b0, -1, h);   // jr
    run_instr(32'hF800_0000, 1'b0, -1, h);               // undefined 11111
    run_instr({5'b11010, 27'($urandom)}, 1'b0, -1, h);   // nop
    run_instr(32'h0880_0005, 1'b1, -1, h);               // Stop in T0
    hold_halt(3);
    do_clear(1);
    run_instr({5'b00000, 27'($urandom)}, 1'b0, 5, h);    // clear during EXEC4 of ld
    run_instr({5'b11011, 27'($urandom)}, 1'b0, -1, h);   // halt
    hold_halt(20);
    do_clear(3);
    run_instr({5'b00011, 27'($urandom)}, 1'b0, -1, h);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ir;
      logic        stp;
      int          ab;
      ir  = rand_ir($urandom_range(0, 7));
      stp = ($urandom_range(0, 7) == 0);
      ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : -1;
      run_instr(ir, stp, ab, h);
      if (h) begin
        hold_halt($urandom_range(1, 4));
        do_clear($urandom_range(1, 2));
      end
    end
    stim_done = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
